// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DROP  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam logic [31:0] WORD_INC = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_word_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_if.sv
// Instruction memory request/ack bus between the fetch unit and imem.
interface fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_holdbuf.sv
// One-entry skid buffer for a word acked while IF/ID is stalled.
module fetch_holdbuf
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clr,
  input  fetch_word_t wr_word,
  output logic        vld,
  output fetch_word_t rd_word
);
  logic        vld_q, vld_d;
  fetch_word_t word_q, word_d;

  always_comb begin
    vld_d  = vld_q;
    word_d = word_q;
    if (load) begin
      vld_d  = 1'b1;
      word_d = wr_word;
    end else if (clr) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      word_q <= '0;
    end else begin
      vld_q  <= vld_d;
      word_q <= word_d;
    end
  end

  assign vld     = vld_q;
  assign rd_word = word_q;
endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch with IF/ID register and redirect.
// Optional FETCH_DELAY_SLOT_EN: word following a branch is delivered as a delay slot.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        isbranch,
  input  logic [31:0] branch_pc,
  fetch_if.master     imem,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst,
  output logic        if_id_valid
);
  fetch_state_e state_q, state_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  pend_q, pend_d;
  logic         pend_vld_q, pend_vld_d;
  logic         started_q, started_d;
  fetch_word_t  ifid_q, ifid_d;
  logic         ifid_vld_q, ifid_vld_d;

  logic         buf_load, buf_clr, buf_vld;
  fetch_word_t  buf_word, acked_word;
  logic         req, ack, redirect;
  logic [31:0]  target, seq_next;

  // Request stays low until the first edge after reset release.
  assign req        = started_q && (state_q != ST_HOLD);
  assign ack        = req && imem.imem_ack;
  assign redirect   = isbranch && !stall;
  assign target     = word_align(branch_pc);
  assign acked_word = '{pc: addr_q, inst: imem.imem_rdata};
  assign seq_next   = pend_vld_q ? pend_q : addr_q + WORD_INC;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    started_d  = 1'b1;
    ifid_d     = ifid_q;
    ifid_vld_d = ifid_vld_q;
    buf_load   = 1'b0;
    buf_clr    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (redirect) begin
`ifdef FETCH_DELAY_SLOT_EN
          if (ack) begin
            ifid_d     = acked_word;
            ifid_vld_d = 1'b1;
            addr_d     = target;
            pend_vld_d = 1'b0;
          end else if (!req) begin
            ifid_vld_d = 1'b0;
            addr_d     = target;
            pend_vld_d = 1'b0;
          end else begin
            // In-flight word is the delay slot; branch target waits behind it.
            ifid_vld_d = 1'b0;
            pend_d     = target;
            pend_vld_d = 1'b1;
          end
`else
          ifid_vld_d = 1'b0;
          if (req && !ack) begin
            pend_d     = target;
            pend_vld_d = 1'b1;
            state_d    = ST_DROP;
          end else begin
            addr_d = target;
          end
`endif
        end else if (ack) begin
          if (!stall) begin
            ifid_d     = acked_word;
            ifid_vld_d = 1'b1;
            addr_d     = seq_next;
            pend_vld_d = 1'b0;
          end else begin
            buf_load = 1'b1;
            state_d  = ST_HOLD;
          end
        end else if (!stall) begin
          ifid_vld_d = 1'b0;
        end
      end
      ST_HOLD: begin
        if (!stall) begin
          buf_clr    = 1'b1;
          state_d    = ST_FETCH;
          pend_vld_d = 1'b0;
`ifdef FETCH_DELAY_SLOT_EN
          ifid_d     = buf_word;
          ifid_vld_d = buf_vld;
          addr_d     = redirect ? target
                     : (pend_vld_q ? pend_q : buf_word.pc + WORD_INC);
`else
          if (redirect) begin
            ifid_vld_d = 1'b0;
            addr_d     = target;
          end else begin
            ifid_d     = buf_word;
            ifid_vld_d = buf_vld;
            addr_d     = buf_word.pc + WORD_INC;
          end
`endif
        end
      end
      ST_DROP: begin
        // Address stays on the abandoned request until imem acks it.
        if (redirect) pend_d = target;
        if (!stall)   ifid_vld_d = 1'b0;
        if (ack) begin
          addr_d     = redirect ? target : pend_q;
          pend_vld_d = 1'b0;
          state_d    = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      addr_q     <= RESET_PC;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      started_q  <= 1'b0;
      ifid_q     <= '{pc: 32'h0, inst: NOP_INST};
      ifid_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      started_q  <= started_d;
      ifid_q     <= ifid_d;
      ifid_vld_q <= ifid_vld_d;
    end
  end

  fetch_holdbuf u_holdbuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (buf_load),
    .clr     (buf_clr),
    .wr_word (acked_word),
    .vld     (buf_vld),
    .rd_word (buf_word)
  );

  assign imem.imem_req  = req;
  assign imem.imem_addr = addr_q;
  assign if_id_pc       = ifid_q.pc;
  assign if_id_inst     = ifid_q.inst;
  assign if_id_valid    = ifid_vld_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; imem returns addr ^ 0xDEAD0000 as the word.
module tb_fetch_unit;
  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        isbranch;
  logic [31:0] branch_pc;
  logic [31:0] if_id_pc, if_id_inst;
  logic        if_id_valid;
  int          n_chk;
  int          n_pass;

  fetch_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .isbranch    (isbranch),
    .branch_pc   (branch_pc),
    .imem        (bus),
    .if_id_pc    (if_id_pc),
    .if_id_inst  (if_id_inst),
    .if_id_valid (if_id_valid)
  );

  assign bus.imem_rdata = bus.imem_addr ^ 32'hDEAD_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FETCH_DELAY_SLOT_EN
  localparam logic DS = 1'b1;
`else
  localparam logic DS = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0; stall = 1'b0; isbranch = 1'b0; branch_pc = '0;
    bus.imem_ack = 1'b1;
    tick; tick;
    chk("rst_req",   {31'd0, bus.imem_req}, 32'd0);
    chk("rst_addr",  bus.imem_addr, 32'h0);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_pc",    if_id_pc, 32'h0);
    chk("rst_inst",  if_id_inst, 32'h0);

    // Streaming fetch with ack always high
    rst_n = 1'b1;
    tick;
    chk("start_req",  {31'd0, bus.imem_req}, 32'd1);
    chk("start_addr", bus.imem_addr, 32'h0);
    tick;
    chk("s0_pc",    if_id_pc, 32'h0);
    chk("s0_inst",  if_id_inst, 32'hDEAD_0000);
    chk("s0_valid", {31'd0, if_id_valid}, 32'd1);
    chk("s0_addr",  bus.imem_addr, 32'h4);
    tick;
    chk("s1_pc",   if_id_pc, 32'h4);
    chk("s1_inst", if_id_inst, 32'hDEAD_0004);
    chk("s1_addr", bus.imem_addr, 32'h8);

    // Stall while acked word at 0x8 arrives
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("hold_req",   {31'd0, bus.imem_req}, 32'd0);
      chk("hold_pc",    if_id_pc, 32'h4);
      chk("hold_valid", {31'd0, if_id_valid}, 32'd1);
    end
    stall = 1'b0;
    tick;
    chk("unhold_pc",   if_id_pc, 32'h8);
    chk("unhold_inst", if_id_inst, 32'hDEAD_0008);
    chk("unhold_addr", bus.imem_addr, 32'hC);
    chk("unhold_req",  {31'd0, bus.imem_req}, 32'd1);

    // Redirect with same-cycle ack, misaligned target
    isbranch = 1'b1; branch_pc = 32'h0000_0103;
    tick;
    isbranch = 1'b0;
    chk("br_valid", {31'd0, if_id_valid}, {31'd0, DS});
    chk("br_addr",  bus.imem_addr, 32'h100);
    if (DS) chk("br_ds_pc", if_id_pc, 32'hC);
    tick;
    chk("br_tgt_pc",   if_id_pc, 32'h100);
    chk("br_tgt_inst", if_id_inst, 32'hDEAD_0100);
    chk("br_tgt_addr", bus.imem_addr, 32'h104);

    // Redirect while request to 0x20 outstanding, ack two cycles late
    isbranch = 1'b1; branch_pc = 32'h20;
    tick;
    isbranch = 1'b0; bus.imem_ack = 1'b0;
    chk("pend_addr", bus.imem_addr, 32'h20);
    tick;
    chk("pend_bub", {31'd0, if_id_valid}, 32'd0);
    isbranch = 1'b1; branch_pc = 32'h100;
    tick;
    isbranch = 1'b0;
    chk("drop_addr0", bus.imem_addr, 32'h20);
    chk("drop_req0",  {31'd0, bus.imem_req}, 32'd1);
    tick;
    chk("drop_addr1", bus.imem_addr, 32'h20);
    bus.imem_ack = 1'b1;
    tick;
    chk("drop_done_addr",  bus.imem_addr, 32'h100);
    chk("drop_done_valid", {31'd0, if_id_valid}, {31'd0, DS});
    if (DS) chk("ds_late_pc", if_id_pc, 32'h20);
    tick;
    chk("drop_tgt_pc",   if_id_pc, 32'h100);
    chk("drop_tgt_addr", bus.imem_addr, 32'h104);

    // Address wrap at top of space
    isbranch = 1'b1; branch_pc = 32'hFFFF_FFFC;
    tick;
    isbranch = 1'b0;
    chk("wrap_top", bus.imem_addr, 32'hFFFF_FFFC);
    tick;
    chk("wrap_pc",   if_id_pc, 32'hFFFF_FFFC);
    chk("wrap_inst", if_id_inst, 32'h2152_FFFC);
    chk("wrap_addr", bus.imem_addr, 32'h0);

    // Asynchronous reset in the middle of an outstanding request
    isbranch = 1'b1; branch_pc = 32'h80;
    tick;
    isbranch = 1'b0; bus.imem_ack = 1'b0;
    tick;
    chk("mid_addr", bus.imem_addr, 32'h80);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req",   {31'd0, bus.imem_req}, 32'd0);
    chk("arst_addr",  bus.imem_addr, 32'h0);
    chk("arst_pc",    if_id_pc, 32'h0);
    chk("arst_inst",  if_id_inst, 32'h0);
    chk("arst_valid", {31'd0, if_id_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; bus.imem_ack = 1'b1;
    tick;
    chk("rel_req",  {31'd0, bus.imem_req}, 32'd1);
    chk("rel_addr", bus.imem_addr, 32'h0);
    tick;
    chk("rel_pc",    if_id_pc, 32'h0);
    chk("rel_valid", {31'd0, if_id_valid}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
